// File: rtl/memio32_if.sv
// CPU data-port bus between the single-cycle core and the memory/IO responder.
// The CPU drives address, strobes and store data; the responder returns load data.
interface memio32_if;
    logic [31:0] addr;
    logic        memread;
    logic        memwrite;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, memread, memwrite, wdata, input rdata);
    modport slave  (input addr, memread, memwrite, wdata, output rdata);
endinterface

// File: rtl/memio32.sv
// Memory/IO responder: steers CPU loads/stores to block RAM or a small IO bank
// holding LEDs, switches, a prescaled down-counting timer/event counter and bus-error capture.
module memio32 #(
    parameter int          RAM_ADDR_W = 15,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FC00,
    parameter int          PRESCALE   = 50
) (
    input  logic                  clock,
    input  logic                  reset,
    memio32_if.slave              bus,
    output logic                  ram_wea,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_dina,
    input  logic [31:0]           ram_douta,
    input  logic [15:0]           switch_in,
    input  logic                  pulse_in,
    output logic [15:0]           led_out,
    output logic                  timer_irq,
    output logic                  bus_err
);

    localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

    localparam logic [3:0] OFF_LED     = 4'h0;
    localparam logic [3:0] OFF_SW      = 4'h1;
    localparam logic [3:0] OFF_TCTRL   = 4'h4;
    localparam logic [3:0] OFF_TLOAD   = 4'h5;
    localparam logic [3:0] OFF_TCOUNT  = 4'h6;
    localparam logic [3:0] OFF_TSTAT   = 4'h7;
    localparam logic [3:0] OFF_ERRADDR = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic [3:0]      tctrl_q, tctrl_d;      // {IRQ_EN, MODE, AUTO, EN}
    logic [31:0]     tcount_q, tcount_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            done_q, done_d;
    logic [31:0]     tload_q;
    logic [15:0]     led_q;
    logic [31:0]     erraddr_q;
    logic            bus_err_q;
    logic [15:0]     sw_meta_q, sw_sync_q;
    logic            pulse_meta_q, pulse_sync_q, pulse_prev_q;

    logic            ram_sel, io_sel, unmapped, io_wr;
    logic [3:0]      off;
    logic            wr_led, wr_tctrl, wr_tload, wr_tstat;
    logic            tick, expire;
    logic [31:0]     io_rdata, rdata_c;

    assign ram_sel  = (bus.addr[31:RAM_ADDR_W] == '0);
    assign io_sel   = (bus.addr[31:6] == IO_BASE[31:6]);
    assign unmapped = (bus.memread | bus.memwrite) & ~ram_sel & ~io_sel;
    assign off      = bus.addr[5:2];
    assign io_wr    = bus.memwrite & io_sel;
    assign wr_led   = io_wr & (off == OFF_LED);
    assign wr_tctrl = io_wr & (off == OFF_TCTRL);
    assign wr_tload = io_wr & (off == OFF_TLOAD);
    assign wr_tstat = io_wr & (off == OFF_TSTAT);

    assign ram_wea  = bus.memwrite & ram_sel;
    assign ram_addr = bus.addr[RAM_ADDR_W-1:0];
    assign ram_dina = bus.wdata;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        io_rdata = '0;
        case (off)
            OFF_LED:     io_rdata = {16'h0, led_q};
            OFF_SW:      io_rdata = {16'h0, sw_sync_q};
            OFF_TCTRL:   io_rdata = {28'h0, tctrl_q};
            OFF_TLOAD:   io_rdata = tload_q;
            OFF_TCOUNT:  io_rdata = tcount_q;
            OFF_TSTAT:   io_rdata = {31'h0, done_q};
            OFF_ERRADDR: io_rdata = erraddr_q;
            default:     io_rdata = '0;
        endcase
        rdata_c = '0;
        if (bus.memread) begin
            if (ram_sel)     rdata_c = ram_douta;
            else if (io_sel) rdata_c = io_rdata;
        end
    end
    assign bus.rdata = rdata_c;

    assign tick = tctrl_q[2] ? (pulse_sync_q & ~pulse_prev_q) : (presc_q == PRESC_MAX);

    always_comb begin
        state_d  = state_q;
        tctrl_d  = tctrl_q;
        tcount_d = tcount_q;
        presc_d  = presc_q;
        done_d   = done_q;
        expire   = 1'b0;
        if (wr_tstat && bus.wdata[0]) done_d = 1'b0;
        if (wr_tctrl && !bus.wdata[0]) begin
            // Disabling wins over a same-edge expire; count and prescaler freeze.
            tctrl_d = bus.wdata[3:0];
            state_d = S_IDLE;
        end else if (wr_tctrl && state_q != S_RUN) begin
            tctrl_d  = bus.wdata[3:0];
            tcount_d = tload_q;
            presc_d  = '0;
            state_d  = S_RUN;
        end else begin
            if (wr_tctrl) tctrl_d = bus.wdata[3:0];
            if (state_q == S_RUN) begin
                if (!tctrl_q[2]) presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (tcount_q > 32'd1) tcount_d = tcount_q - 32'd1;
                    else                  expire   = 1'b1;
                end
            end
            if (expire) begin
                done_d = 1'b1;
                if (tctrl_d[1]) begin
                    tcount_d = tload_q;
                end else begin
                    tcount_d   = '0;
                    tctrl_d[0] = 1'b0;
                    state_d    = S_HOLD;
                end
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            tctrl_q  <= '0;
            tcount_q <= '0;
            presc_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tctrl_q  <= tctrl_d;
            tcount_q <= tcount_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q     <= '0;
            tload_q   <= '0;
            erraddr_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (wr_led)   led_q     <= bus.wdata[15:0];
            if (wr_tload) tload_q   <= bus.wdata;
            if (unmapped) erraddr_q <= bus.addr;
            bus_err_q <= unmapped;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            pulse_meta_q <= 1'b0;
            pulse_sync_q <= 1'b0;
            pulse_prev_q <= 1'b0;
        end else begin
            sw_meta_q    <= switch_in;
            sw_sync_q    <= sw_meta_q;
            pulse_meta_q <= pulse_in;
            pulse_sync_q <= pulse_meta_q;
            pulse_prev_q <= pulse_sync_q;
        end
    end

    assign led_out   = led_q;
    assign timer_irq = done_q & tctrl_q[3];
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_memio32.sv
// Self-checking bench for memio32: table-driven bus vectors plus hand-timed
// sequences for the timer, event counter, synchronizers and asynchronous reset.
module tb_memio32;

    localparam logic [31:0] A_LED     = 32'hFFFF_FC00;
    localparam logic [31:0] A_SW      = 32'hFFFF_FC04;
    localparam logic [31:0] A_TCTRL   = 32'hFFFF_FC10;
    localparam logic [31:0] A_TLOAD   = 32'hFFFF_FC14;
    localparam logic [31:0] A_TCOUNT  = 32'hFFFF_FC18;
    localparam logic [31:0] A_TSTAT   = 32'hFFFF_FC1C;
    localparam logic [31:0] A_ERRADDR = 32'hFFFF_FC3C;

    logic        clock = 1'b0;
    logic        reset;
    logic        ram_wea;
    logic [14:0] ram_addr;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta;
    logic [15:0] switch_in;
    logic        pulse_in;
    logic [15:0] led_out;
    logic        timer_irq;
    logic        bus_err;

    memio32_if bus ();

    memio32 #(.RAM_ADDR_W(15), .IO_BASE(32'hFFFF_FC00), .PRESCALE(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .ram_wea   (ram_wea),
        .ram_addr  (ram_addr),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta),
        .switch_in (switch_in),
        .pulse_in  (pulse_in),
        .led_out   (led_out),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] douta;
        logic [31:0] exp_rdata;
        logic        exp_wea;
        logic [15:0] exp_led;
        logic        exp_err;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic re,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] douta, input logic [31:0] exp_rdata,
                                input logic exp_wea, input logic [15:0] exp_led,
                                input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
        v.douta = douta; v.exp_rdata = exp_rdata; v.exp_wea = exp_wea;
        v.exp_led = exp_led; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.addr = a; bus.wdata = d; bus.memwrite = 1'b1; bus.memread = 1'b0;
        @(posedge clock); #1;
        bus.memwrite = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clock);
        bus.addr = a; bus.memread = 1'b1; bus.memwrite = 1'b0;
        #1 d = bus.rdata;
        check(name, d, exp);
        @(posedge clock); #1;
        bus.memread = 1'b0;
    endtask

    // Event pulse: high for 3 edges, low for 3 edges; decrement lands on the 3rd high edge.
    task automatic pulse();
        @(negedge clock) pulse_in = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock) pulse_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    // Pulse with a bus write landing on the same edge as the resulting tick.
    task automatic pulse_with_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock) pulse_in = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        bus.addr = a; bus.wdata = d; bus.memwrite = 1'b1;
        @(posedge clock); #1;
        bus.memwrite = 1'b0;
        @(negedge clock) pulse_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk("ram_store",   1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,           32'h0,           1, 16'h0,    0);
        vecs[1]  = mk("ram_load",    0, 1, 32'h0000_0010, 32'h0,         32'h1234_5678,   32'h1234_5678,   0, 16'h0,    0);
        vecs[2]  = mk("no_strobe",   0, 0, 32'h0000_0010, 32'h0,         32'h1234_5678,   32'h0,           0, 16'h0,    0);
        vecs[3]  = mk("led_store",   1, 0, A_LED,         32'h0001_A5A5, 32'h0,           32'h0,           0, 16'hA5A5, 0);
        vecs[4]  = mk("led_load",    0, 1, A_LED,         32'h0,         32'hCAFE_F00D,   32'h0000_A5A5,   0, 16'hA5A5, 0);
        vecs[5]  = mk("led_load_b3", 0, 1, 32'hFFFF_FC03, 32'h0,         32'h0,           32'h0000_A5A5,   0, 16'hA5A5, 0);
        vecs[6]  = mk("ram_top",     1, 0, 32'h0000_7FFC, 32'h1111_2222, 32'h0,           32'h0,           1, 16'hA5A5, 0);
        vecs[7]  = mk("ram_past",    1, 0, 32'h0000_8000, 32'h5555_0000, 32'h0,           32'h0,           0, 16'hA5A5, 1);
        vecs[8]  = mk("unmap_load",  0, 1, 32'h1000_0000, 32'h0,         32'hFFFF_FFFF,   32'h0,           0, 16'hA5A5, 1);
        vecs[9]  = mk("io_hole_ld",  0, 1, 32'hFFFF_FC08, 32'h0,         32'hFFFF_FFFF,   32'h0,           0, 16'hA5A5, 0);
        vecs[10] = mk("io_hole_st",  1, 0, 32'hFFFF_FC08, 32'h0000_FFFF, 32'h0,           32'h0,           0, 16'hA5A5, 0);
        vecs[11] = mk("erraddr_1",   0, 1, A_ERRADDR,     32'h0,         32'h0,           32'h1000_0000,   0, 16'hA5A5, 0);
        vecs[12] = mk("below_io",    0, 1, 32'hFFFF_FBFC, 32'h0,         32'h0,           32'h0,           0, 16'hA5A5, 1);
        vecs[13] = mk("erraddr_2",   0, 1, A_ERRADDR,     32'h0,         32'h0,           32'hFFFF_FBFC,   0, 16'hA5A5, 0);
        vecs[14] = mk("sw_ro_store", 1, 0, A_SW,          32'h0000_1234, 32'h0,           32'h0,           0, 16'hA5A5, 0);

        reset = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.memread = 1'b0; bus.memwrite = 1'b0;
        ram_douta = '0; switch_in = '0; pulse_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        @(negedge clock) reset = 1'b1;
        rd_check("rst_tctrl", A_TCTRL, 32'h0);
        rd_check("rst_tload", A_TLOAD, 32'h0);
        rd_check("rst_tcount", A_TCOUNT, 32'h0);
        rd_check("rst_tstat", A_TSTAT, 32'h0);
        rd_check("rst_erraddr", A_ERRADDR, 32'h0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            bus.addr = vecs[i].addr; bus.wdata = vecs[i].wdata;
            bus.memwrite = vecs[i].we; bus.memread = vecs[i].re;
            ram_douta = vecs[i].douta;
            #1;
            check({vecs[i].name, ".rdata"}, bus.rdata, vecs[i].exp_rdata);
            check({vecs[i].name, ".wea"}, {31'h0, ram_wea}, {31'h0, vecs[i].exp_wea});
            check({vecs[i].name, ".ram_addr"}, {17'h0, ram_addr}, {17'h0, vecs[i].addr[14:0]});
            check({vecs[i].name, ".ram_dina"}, ram_dina, vecs[i].wdata);
            @(posedge clock); #1;
            bus.memwrite = 1'b0; bus.memread = 1'b0;
            check({vecs[i].name, ".led"}, {16'h0, led_out}, {16'h0, vecs[i].exp_led});
            check({vecs[i].name, ".bus_err"}, {31'h0, bus_err}, {31'h0, vecs[i].exp_err});
        end
        ram_douta = '0;

        // Switch synchronizer: new value visible after exactly two edges.
        @(negedge clock);
        bus.addr = A_SW; bus.memread = 1'b1; switch_in = 16'h00F0;
        #1 check("sw_edge0", bus.rdata, 32'h0);
        @(posedge clock); #1 check("sw_edge1", bus.rdata, 32'h0);
        @(posedge clock); #1 check("sw_edge2", bus.rdata, 32'h0000_00F0);
        bus.memread = 1'b0;

        // One-shot timer, PRESCALE=4, TLOAD=3: DONE 12 edges after the EN write.
        wr(A_TLOAD, 32'd3);
        wr(A_TCTRL, 32'h9);
        repeat (11) @(posedge clock);
        #1 check("oneshot_irq_11", {31'h0, timer_irq}, 32'h0);
        @(posedge clock); #1 check("oneshot_irq_12", {31'h0, timer_irq}, 32'h1);
        rd_check("oneshot_tcount", A_TCOUNT, 32'h0);
        rd_check("oneshot_tctrl", A_TCTRL, 32'h8);
        rd_check("oneshot_tstat", A_TSTAT, 32'h1);
        repeat (8) @(posedge clock);
        rd_check("hold_tcount", A_TCOUNT, 32'h0);
        wr(A_TSTAT, 32'h1);
        check("w1c_irq", {31'h0, timer_irq}, 32'h0);

        // TLOAD=0 expires on the first tick.
        wr(A_TLOAD, 32'd0);
        wr(A_TCTRL, 32'h9);
        repeat (3) @(posedge clock);
        #1 check("tload0_irq_3", {31'h0, timer_irq}, 32'h0);
        @(posedge clock); #1 check("tload0_irq_4", {31'h0, timer_irq}, 32'h1);

        // Asynchronous reset mid-run with TCOUNT=7.
        wr(A_TLOAD, 32'd7);
        wr(A_TCTRL, 32'h9);
        rd_check("prerst_tcount", A_TCOUNT, 32'd7);
        check("prerst_irq", {31'h0, timer_irq}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_led", {16'h0, led_out}, 32'h0);
        check("async_rst_irq", {31'h0, timer_irq}, 32'h0);
        check("async_rst_err", {31'h0, bus_err}, 32'h0);
        rd_check("inrst_tcount", A_TCOUNT, 32'h0);
        rd_check("inrst_tctrl", A_TCTRL, 32'h0);
        rd_check("inrst_tload", A_TLOAD, 32'h0);
        rd_check("inrst_tstat", A_TSTAT, 32'h0);
        rd_check("inrst_erraddr", A_ERRADDR, 32'h0);
        rd_check("inrst_sw", A_SW, 32'h0);
        @(negedge clock) reset = 1'b1;
        repeat (20) @(posedge clock);
        rd_check("postrst_tcount", A_TCOUNT, 32'h0);
        rd_check("postrst_tstat", A_TSTAT, 32'h0);

        // Counter mode with auto-reload, TLOAD=2.
        wr(A_TLOAD, 32'd2);
        wr(A_TCTRL, 32'h7);
        @(negedge clock);
        pulse_in = 1'b1; bus.addr = A_TCOUNT; bus.memread = 1'b1;
        @(posedge clock);
        @(posedge clock); #1 check("cnt_edge2", bus.rdata, 32'd2);
        @(posedge clock); #1 check("cnt_edge3", bus.rdata, 32'd1);
        bus.memread = 1'b0;
        @(negedge clock) pulse_in = 1'b0;
        repeat (3) @(posedge clock);
        pulse();
        rd_check("p2_tcount", A_TCOUNT, 32'd2);
        rd_check("p2_tstat", A_TSTAT, 32'h1);
        rd_check("p2_tctrl", A_TCTRL, 32'h7);
        check("p2_irq_masked", {31'h0, timer_irq}, 32'h0);
        wr(A_TSTAT, 32'h1);
        rd_check("p2_cleared", A_TSTAT, 32'h0);
        pulse();
        rd_check("p3_tcount", A_TCOUNT, 32'd1);
        pulse_with_write(A_TSTAT, 32'h1);
        rd_check("p4_set_wins", A_TSTAT, 32'h1);
        rd_check("p4_tcount", A_TCOUNT, 32'd2);

        // EN=0 write on the expire edge wins: no DONE, count frozen.
        wr(A_TSTAT, 32'h1);
        pulse();
        rd_check("p5_tcount", A_TCOUNT, 32'd1);
        pulse_with_write(A_TCTRL, 32'h6);
        rd_check("p6_no_done", A_TSTAT, 32'h0);
        rd_check("p6_frozen", A_TCOUNT, 32'd1);
        rd_check("p6_tctrl", A_TCTRL, 32'h6);

        // Store to read-only TCOUNT is ignored and is not a bus error.
        wr(A_TCOUNT, 32'hFFFF_FFFF);
        check("ro_store_err", {31'h0, bus_err}, 32'h0);
        rd_check("ro_store_tcount", A_TCOUNT, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
